trap_unit: RTL

//  Responder for the CPU's exceptions_o vector. The monitor only halts on ECALL/EBREAK; this block takes the trap instead.
//  On a trap it saves mepc/mcause and redirects the PC to mtvec; on mret it redirects back to mepc.

---
 rtl/trap_unit_if.sv | 30 +++
 rtl/trap_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/trap_unit_if.sv
// Purpose: bundles the trap_unit bus: exception/mret inputs, CSR port, redirect/stall/status outputs.
// Ports: master = CPU/PC side (drives events and CSR access), slave = trap_unit.
// Latency/backpressure: none added here; the signals are plain wires.
interface trap_unit_if #(
  parameter int DATA_WIDTH = 64
);
  logic [7:0]            exception_i;
  logic [DATA_WIDTH-1:0] pc_i;
  logic                  mret_i;
  logic                  csr_we_i;
  logic [11:0]           csr_addr_i;
  logic [DATA_WIDTH-1:0] csr_wdata_i;
  logic [DATA_WIDTH-1:0] csr_rdata_o;
  logic                  redirect_valid_o;
  logic [DATA_WIDTH-1:0] redirect_pc_o;
  logic                  stall_o;
  logic                  halt_o;
  logic                  fatal_o;
  logic [31:0]           trap_count_o;

  modport master (
    output exception_i, pc_i, mret_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, redirect_valid_o, redirect_pc_o, stall_o, halt_o, fatal_o, trap_count_o
  );

  modport slave (
    input  exception_i, pc_i, mret_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, redirect_valid_o, redirect_pc_o, stall_o, halt_o, fatal_o, trap_count_o
  );
endinterface

// File: rtl/trap_unit.sv
// Purpose: takes CPU exceptions/mret, saves mepc/mcause, redirects PC to mtvec or back to mepc.
// Latency: event in cycle N -> one-cycle redirect pulse in N+1; CSR reads are combinational.
// Backpressure: stall_o (combinational) holds the PC while an event is pending or while halted.
// Ports: clk_i, rst_i (sync, active-high); bus (slave): exception_i[7:0], pc_i, mret_i,
//   csr_we_i/csr_addr_i/csr_wdata_i/csr_rdata_o, redirect_valid_o/redirect_pc_o, stall_o,
//   halt_o, fatal_o, trap_count_o[31:0].
module trap_unit #(
  parameter int DATA_WIDTH = 64
) (
  input logic         clk_i,
  input logic         rst_i,
  trap_unit_if.slave  bus
);

  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP,
    S_RETURN,
    S_HALT,
    S_FATAL
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mtvec;
  logic [DATA_WIDTH-1:0] mscratch;
  logic [DATA_WIDTH-1:0] mepc;
  logic [DATA_WIDTH-1:0] mcause;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  redirect_valid;
  logic [31:0]           trap_count;

  logic                  trap_hit;
  logic [DATA_WIDTH-1:0] trap_cause;
  logic [DATA_WIDTH-1:0] csr_wdata_aligned;
  logic                  csr_wr_ok;

  // exception_i[7:5] and the low pc bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.exception_i[7:5], bus.pc_i[1:0]};

  assign trap_hit          = bus.exception_i[0] | bus.exception_i[1] |
                             bus.exception_i[3] | bus.exception_i[4];
  assign csr_wdata_aligned = {bus.csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
  assign csr_wr_ok         = (state == S_IDLE) || (state == S_TRAP);

  // First set bit wins: fetch, decode, ECALL, EBREAK.
  always_comb begin
    trap_cause = '0;
    if (bus.exception_i[0])      trap_cause = DATA_WIDTH'(1);
    else if (bus.exception_i[1]) trap_cause = DATA_WIDTH'(2);
    else if (bus.exception_i[3]) trap_cause = DATA_WIDTH'(11);
    else if (bus.exception_i[4]) trap_cause = DATA_WIDTH'(3);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      mtvec          <= '0;
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_count     <= '0;
    end else begin
      // Software writes go first so that a same-cycle trap capture below overrides them.
      if (csr_wr_ok && bus.csr_we_i) begin
        case (bus.csr_addr_i)
          ADDR_MTVEC:    mtvec    <= csr_wdata_aligned;
          ADDR_MSCRATCH: mscratch <= bus.csr_wdata_i;
          ADDR_MEPC:     mepc     <= csr_wdata_aligned;
          ADDR_MCAUSE:   mcause   <= bus.csr_wdata_i;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
          if (bus.exception_i[2]) begin
            state <= S_FATAL;
          end else if (trap_hit) begin
            mcause <= trap_cause;
            mepc   <= {bus.pc_i[DATA_WIDTH-1:2], 2'b00};
            if (trap_count != 32'hFFFF_FFFF) trap_count <= trap_count + 32'd1;
            if (mtvec == '0) begin
              state <= S_HALT;
            end else begin
              // Target is the mtvec in force when the trap was raised.
              state          <= S_TRAP;
              redirect_valid <= 1'b1;
              redirect_pc    <= mtvec;
            end
          end else if (bus.mret_i) begin
            state          <= S_RETURN;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
          end
        end
        S_TRAP, S_RETURN: begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
        end
        default: ; // HALT and FATAL hold until reset
      endcase
    end
  end

  always_comb begin
    bus.csr_rdata_o = '0;
    case (bus.csr_addr_i)
      ADDR_MTVEC:    bus.csr_rdata_o = mtvec;
      ADDR_MSCRATCH: bus.csr_rdata_o = mscratch;
      ADDR_MEPC:     bus.csr_rdata_o = mepc;
      ADDR_MCAUSE:   bus.csr_rdata_o = mcause;
      default: ;
    endcase
  end

  assign bus.stall_o          = (state != S_IDLE) ||
                                (|bus.exception_i[4:0]) || bus.mret_i;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;
  assign bus.halt_o           = (state == S_HALT) || (state == S_FATAL);
  assign bus.fatal_o          = (state == S_FATAL);
  assign bus.trap_count_o     = trap_count;

endmodule
